// File: rtl/demultiplexador_pkg.sv
// demultiplexador_pkg
// Shared encodings for the 1-to-3 distribution demultiplexer and the
// 3-input datapath multiplexer callers.
//   SEL_*        : destination select codes
//   estado_canal_t : per-channel holding register state (VAZIO / CHEIO)
package demultiplexador_pkg;

    localparam logic [1:0] SEL_SAIDA0   = 2'b00;
    localparam logic [1:0] SEL_SAIDA1   = 2'b01;
    localparam logic [1:0] SEL_SAIDA2   = 2'b10;
    localparam logic [1:0] SEL_INVALIDA = 2'b11;

    localparam int NUM_CANAIS = 3;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_canal_t;

endpackage

// File: rtl/demultiplexador_registro_saida.sv
// registro_saida
// One-entry valid/ready holding register for a single destination channel.
//
// state | meaning
// VAZIO | register empty, valido=0
// CHEIO | register holds a word, valido=1
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   carga          : load dado this edge (caller guarantees room, i.e.
//                    empty or draining in the same edge)
//   dado           : word to load
//   pronto         : destination consumes the held word
//   saida, valido  : held word and its valid flag
module registro_saida
    import demultiplexador_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               carga,
    input  logic [LARGURA-1:0] dado,
    input  logic               pronto,
    output logic [LARGURA-1:0] saida,
    output logic               valido
);

    estado_canal_t estado;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= VAZIO;
            saida  <= '0;
            valido <= 1'b0;
        end else begin
            case (estado)
                VAZIO: begin
                    if (carga) begin
                        estado <= CHEIO;
                        saida  <= dado;
                        valido <= 1'b1;
                    end
                end
                CHEIO: begin
                    // A load coinciding with a drain replaces the word with no bubble.
                    if (carga) begin
                        saida <= dado;
                    end else if (pronto) begin
                        estado <= VAZIO;
                        valido <= 1'b0;
                    end
                end
                default: begin
                    estado <= VAZIO;
                    valido <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/demultiplexador.sv
// demultiplexador
// Registered 1-to-3 demultiplexer: one source word with valid/ready is
// routed by selecao to one of three one-entry destination registers.
// A stalled destination only blocks words addressed to it. Words with
// selecao=11 are dropped, flagged by a one-cycle erro_selecao pulse and
// counted in a saturating discard counter.
//
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   entrada, selecao               : source word and destination select
//   entrada_valido, entrada_pronto : source handshake
//   saidaK, saidaK_valido, saidaK_pronto : destination K register/handshake
//   erro_selecao                   : pulse after an invalid word is accepted
//   descartes                      : saturating count of dropped words
module demultiplexador
    import demultiplexador_pkg::*;
#(
    parameter int LARGURA          = 8,
    parameter int LARGURA_CONTADOR = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [LARGURA-1:0]          entrada,
    input  logic [1:0]                  selecao,
    input  logic                        entrada_valido,
    output logic                        entrada_pronto,
    output logic [LARGURA-1:0]          saida0,
    output logic [LARGURA-1:0]          saida1,
    output logic [LARGURA-1:0]          saida2,
    output logic                        saida0_valido,
    output logic                        saida1_valido,
    output logic                        saida2_valido,
    input  logic                        saida0_pronto,
    input  logic                        saida1_pronto,
    input  logic                        saida2_pronto,
    output logic                        erro_selecao,
    output logic [LARGURA_CONTADOR-1:0] descartes
);

    logic aceita;
    logic invalida;
    logic [NUM_CANAIS-1:0] carga;

    // Ready never looks at entrada_valido, so the source may wait on it freely.
    always_comb begin
        entrada_pronto = 1'b1;
        case (selecao)
            SEL_SAIDA0: entrada_pronto = !saida0_valido || saida0_pronto;
            SEL_SAIDA1: entrada_pronto = !saida1_valido || saida1_pronto;
            SEL_SAIDA2: entrada_pronto = !saida2_valido || saida2_pronto;
            default:    entrada_pronto = 1'b1;
        endcase
    end

    assign aceita   = entrada_valido && entrada_pronto;
    assign invalida = aceita && (selecao == SEL_INVALIDA);

    assign carga[0] = aceita && (selecao == SEL_SAIDA0);
    assign carga[1] = aceita && (selecao == SEL_SAIDA1);
    assign carga[2] = aceita && (selecao == SEL_SAIDA2);

    registro_saida #(.LARGURA(LARGURA)) u_registro0 (
        .clock   (clock),
        .reset_n (reset_n),
        .carga   (carga[0]),
        .dado    (entrada),
        .pronto  (saida0_pronto),
        .saida   (saida0),
        .valido  (saida0_valido)
    );

    registro_saida #(.LARGURA(LARGURA)) u_registro1 (
        .clock   (clock),
        .reset_n (reset_n),
        .carga   (carga[1]),
        .dado    (entrada),
        .pronto  (saida1_pronto),
        .saida   (saida1),
        .valido  (saida1_valido)
    );

    registro_saida #(.LARGURA(LARGURA)) u_registro2 (
        .clock   (clock),
        .reset_n (reset_n),
        .carga   (carga[2]),
        .dado    (entrada),
        .pronto  (saida2_pronto),
        .saida   (saida2),
        .valido  (saida2_valido)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            erro_selecao <= 1'b0;
            descartes    <= '0;
        end else begin
            erro_selecao <= invalida;
            // Saturate: once all ones, further discards are not counted.
            if (invalida && (descartes != {LARGURA_CONTADOR{1'b1}})) begin
                descartes <= descartes + 1'b1;
            end
        end
    end

endmodule
